ch9350_mouse_tx: RTL and testbench

Serialises mouse reports into CH9350-format UART frames at 8N1. It is the transmit-side counterpart of the CH9350 mouse frame receiver in the webcamera/box peripheral. Its uses are a host-side mouse emulator and a loopback source for the receiver. It accepts one report at a time through a valid/ready handshake, emits a fixed 12-byte frame, then holds the line idle for a programmable gap before accepting the next report.

---
 rtl/ch9350_pkg.sv | 23 ++
 rtl/ch9350_mouse_tx_uart_tx.sv | 105 ++++++++++
 rtl/ch9350_mouse_tx.sv | 161 ++++++++++++++++
 tb/tb_ch9350_mouse_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ch9350_pkg.sv
// Shared constants, state type and timing helper for the CH9350 mouse frame transmitter.
package ch9350_pkg;

  localparam logic [7:0] HDR0 = 8'h57;
  localparam logic [7:0] HDR1 = 8'hAB;
  localparam logic [7:0] HDR2 = 8'h88;
  localparam logic [7:0] LEN  = 8'h08;
  localparam logic [7:0] TYPE = 8'h01;

  localparam int FRAME_BYTES = 12;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  // Clock cycles per UART bit, truncated.
  function automatic int bit_cycles(input int clk_mhz, input int baud);
    return (clk_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/ch9350_mouse_tx_uart_tx.sv
// 8N1 UART transmitter; accepts a new byte during the last stop-bit cycle so bytes run back-to-back.
module uart_tx
  import ch9350_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_pin
);

  localparam int BIT_CYC = bit_cycles(CLK_FRE, BAUD_RATE);
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             pin_q, pin_d;
  logic             cyc_last;

  assign cyc_last = (cyc_q == CNT_W'(BIT_CYC - 1));
  assign tx_pin   = pin_q;

  // NOTE: every signal written here gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    pin_d         = pin_q;
    tx_data_ready = (state_q == U_IDLE) || ((state_q == U_STOP) && cyc_last);

    if (tx_data_valid && tx_data_ready) begin
      state_d = U_START;
      cyc_d   = '0;
      shift_d = tx_data;
      pin_d   = 1'b0;
    end else begin
      unique case (state_q)
        U_IDLE: pin_d = 1'b1;
        U_START: begin
          if (cyc_last) begin
            state_d = U_DATA;
            cyc_d   = '0;
            bit_d   = 3'd0;
            pin_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        U_DATA: begin
          if (cyc_last) begin
            cyc_d = '0;
            if (bit_q == 3'd7) begin
              state_d = U_STOP;
              pin_d   = 1'b1;
            end else begin
              bit_d   = bit_q + 3'd1;
              pin_d   = shift_q[0];
              shift_d = {1'b0, shift_q[7:1]};
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        U_STOP: begin
          if (cyc_last) state_d = U_IDLE;
          else          cyc_d   = cyc_q + 1'b1;
        end
        default: state_d = U_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= U_IDLE;
      cyc_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      pin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
    end
  end

endmodule

// File: rtl/ch9350_mouse_tx.sv
// CH9350 mouse report serialiser: 12-byte 8N1 frame followed by an idle gap.
// Define CH9350_TX_CHKSUM_EN to send a real checksum byte instead of 0x00.
module ch9350_mouse_tx
  import ch9350_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int GAP_BITS  = 20
) (
  input  logic        CLK_50M,
  input  logic        rst_n,
  input  logic        report_valid,
  output logic        report_ready,
  input  logic        key_l,
  input  logic        key_m,
  input  logic        key_r,
  input  logic [15:0] dx,
  input  logic [15:0] dy,
  input  logic [7:0]  wheel,
  output logic        uart_txd,
  output logic        busy,
  output logic        frame_done
);

  localparam int BIT_CYC = bit_cycles(CLK_FRE, BAUD_RATE);
  localparam int GAP_CYC = GAP_BITS * BIT_CYC;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             frame_done_q, frame_done_d;
  logic             capture;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic [3:0]       sel;
  logic [7:0]       chk_byte;

  logic [2:0]       key_q;
  logic [15:0]      dx_q;
  logic [15:0]      dy_q;
  logic [7:0]       wheel_q;

  assign report_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign frame_done   = frame_done_q;

  // Byte 0 is a constant, so it is handed to the UART in the handshake cycle itself.
  assign sel = (state_q == IDLE) ? 4'd0 : idx_q;

  always_comb begin
    tx_data = 8'h00;
    case (sel)
      4'd0:    tx_data = HDR0;
      4'd1:    tx_data = HDR1;
      4'd2:    tx_data = HDR2;
      4'd3:    tx_data = LEN;
      4'd4:    tx_data = TYPE;
      4'd5:    tx_data = {5'b0, key_q};
      4'd6:    tx_data = dx_q[7:0];
      4'd7:    tx_data = dx_q[15:8];
      4'd8:    tx_data = dy_q[7:0];
      4'd9:    tx_data = dy_q[15:8];
      4'd10:   tx_data = wheel_q;
      4'd11:   tx_data = chk_byte;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    frame_done_d = 1'b0;
    capture      = 1'b0;
    tx_valid     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (report_valid) begin
          capture  = 1'b1;
          tx_valid = 1'b1;
          idx_d    = 4'd1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (idx_q < 4'(FRAME_BYTES)) begin
          tx_valid = 1'b1;
          if (tx_ready) idx_d = idx_q + 4'd1;
        end else if (tx_ready) begin
          // UART is ready again only in the final stop-bit cycle of byte 11.
          state_d      = GAP;
          gap_d        = '0;
          frame_done_d = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      gap_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: holding registers are pure datapath, always written at capture before being read, so they carry no reset.
  always_ff @(posedge CLK_50M) begin
    if (capture) begin
      key_q   <= {key_m, key_r, key_l};
      dx_q    <= dx;
      dy_q    <= dy;
      wheel_q <= wheel;
    end
  end

`ifdef CH9350_TX_CHKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= 8'h00;
    end else if (capture) begin
      chk_q <= 8'h00;
    end else if (tx_valid && tx_ready && (sel >= 4'd5) && (sel <= 4'd10)) begin
      chk_q <= chk_q + tx_data;
    end
  end

  assign chk_byte = chk_q;
`else
  assign chk_byte = 8'h00;
`endif

  uart_tx #(
    .CLK_FRE   (CLK_FRE),
    .BAUD_RATE (BAUD_RATE)
  ) u_uart_tx (
    .clk           (CLK_50M),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_data_valid (tx_valid),
    .tx_data_ready (tx_ready),
    .tx_pin        (uart_txd)
  );

endmodule

// File: tb/tb_ch9350_mouse_tx.sv
// Directed bench for ch9350_mouse_tx: decodes the serial line and checks frame bytes, timing, gap and reset.
module tb_ch9350_mouse_tx;

  // 1 MHz / 100000 baud -> 10 cycles per bit, keeps the run short.
  localparam int BIT       = 10;
  localparam int GAP_BITS  = 20;
  localparam int GAP_CYC   = GAP_BITS * BIT;
  localparam int FRAME_CYC = 120 * BIT;

  logic        CLK_50M = 1'b0;
  logic        rst_n;
  logic        report_valid;
  logic        report_ready;
  logic        key_l, key_m, key_r;
  logic [15:0] dx, dy;
  logic [7:0]  wheel;
  logic        uart_txd;
  logic        busy;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] chk1, chk2, chk4;

  ch9350_mouse_tx #(
    .CLK_FRE   (1),
    .BAUD_RATE (100000),
    .GAP_BITS  (GAP_BITS)
  ) dut (
    .CLK_50M      (CLK_50M),
    .rst_n        (rst_n),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .key_l        (key_l),
    .key_m        (key_m),
    .key_r        (key_r),
    .dx           (dx),
    .dy           (dy),
    .wheel        (wheel),
    .uart_txd     (uart_txd),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 CLK_50M = ~CLK_50M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK_50M);
  endtask

  task automatic set_report(input logic l, input logic r, input logic m,
                            input logic [15:0] x, input logic [15:0] y, input logic [7:0] w);
    key_l = l;
    key_r = r;
    key_m = m;
    dx    = x;
    dy    = y;
    wheel = w;
  endtask

  // Called at the negedge of the first start-bit cycle; returns at the negedge one cycle after frame_done.
  task automatic decode_frame(input string name, input logic [95:0] exp);
    int         pos;
    int         framing_err;
    logic [7:0] got;
    pos         = 0;
    framing_err = 0;
    for (int j = 0; j < 12; j++) begin
      got = 8'h00;
      for (int k = 0; k < 10; k++) begin
        while (pos < (10 * j + k) * BIT + BIT / 2) begin
          @(negedge CLK_50M);
          pos++;
        end
        if (k == 0) begin
          if (uart_txd !== 1'b0) framing_err++;
        end else if (k == 9) begin
          if (uart_txd !== 1'b1) framing_err++;
        end else begin
          got[k-1] = uart_txd;
        end
      end
      check($sformatf("%s byte%0d", name, j), 32'(got), 32'(exp[95 - 8 * j -: 8]));
    end
    check($sformatf("%s framing", name), 32'(framing_err), 32'd0);
    while (pos < FRAME_CYC - 1) begin
      @(negedge CLK_50M);
      pos++;
    end
    check($sformatf("%s frame_done early", name), 32'(frame_done), 32'd0);
    check($sformatf("%s busy last bit", name), 32'(busy), 32'd1);
    step(1);
    check($sformatf("%s frame_done at 120 bits", name), 32'(frame_done), 32'd1);
    step(1);
    check($sformatf("%s frame_done width", name), 32'(frame_done), 32'd0);
  endtask

  // Starts one cycle after frame_done; returns on the cycle report_ready should reappear.
  task automatic gap_phase(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < GAP_CYC - 2; i++) begin
      if (uart_txd !== 1'b1 || report_ready !== 1'b0 || busy !== 1'b1) bad++;
      step(1);
    end
    check($sformatf("%s gap line idle", name), 32'(bad), 32'd0);
    check($sformatf("%s ready before gap end", name), 32'(report_ready), 32'd0);
    step(1);
    check($sformatf("%s ready at gap end", name), 32'(report_ready), 32'd1);
    check($sformatf("%s busy at gap end", name), 32'(busy), 32'd0);
    check($sformatf("%s txd at gap end", name), 32'(uart_txd), 32'd1);
  endtask

  initial begin
`ifdef CH9350_TX_CHKSUM_EN
    chk1 = 8'h04;
    chk2 = 8'h12;
    chk4 = 8'hA7;
`else
    chk1 = 8'h00;
    chk2 = 8'h00;
    chk4 = 8'h00;
`endif
    rst_n        = 1'b0;
    report_valid = 1'b0;
    set_report(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00);

    step(2);
    check("reset txd", 32'(uart_txd), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset ready", 32'(report_ready), 32'd1);
    rst_n = 1'b1;
    step(2);

    // Frame 1: left button, dx = +5, dy = -2, wheel up.
    set_report(1'b1, 1'b0, 1'b0, 16'h0005, 16'hFFFE, 8'h01);
    report_valid = 1'b1;
    check("f1 ready before handshake", 32'(report_ready), 32'd1);
    step(1);
    check("f1 start bit latency", 32'(uart_txd), 32'd0);
    check("f1 busy rises", 32'(busy), 32'd1);
    check("f1 ready drops", 32'(report_ready), 32'd0);
    report_valid = 1'b0;
    set_report(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 8'h7E);
    decode_frame("f1", {88'h57_AB_88_08_01_01_05_00_FE_FF_01, chk1});
    gap_phase("f1");

    // Frame 2: valid held high throughout; inputs change mid-frame to the next report.
    set_report(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 8'h00);
    report_valid = 1'b1;
    step(1);
    check("f2 start bit latency", 32'(uart_txd), 32'd0);
    set_report(1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 8'h01);
    decode_frame("f2", {88'h57_AB_88_08_01_02_10_00_00_00_00, chk2});
    gap_phase("f2");

    // Frame 3 starts immediately from the held valid, then reset lands during byte 6.
    step(1);
    check("f3 start after gap", 32'(uart_txd), 32'd0);
    step(60 * BIT + 3);
    check("f3 byte6 start bit", 32'(uart_txd), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midframe reset txd", 32'(uart_txd), 32'd1);
    check("midframe reset busy", 32'(busy), 32'd0);
    check("midframe reset ready", 32'(report_ready), 32'd1);
    check("midframe reset frame_done", 32'(frame_done), 32'd0);
    report_valid = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3 * BIT);
    check("post reset txd idle", 32'(uart_txd), 32'd1);
    check("post reset busy", 32'(busy), 32'd0);

    // Frame 4: middle + left buttons, dx = -128, dy = 0x0123, wheel down.
    set_report(1'b1, 1'b0, 1'b1, 16'hFF80, 16'h0123, 8'hFF);
    report_valid = 1'b1;
    step(1);
    check("f4 start bit latency", 32'(uart_txd), 32'd0);
    report_valid = 1'b0;
    decode_frame("f4", {88'h57_AB_88_08_01_05_80_FF_23_01_FF, chk4});
    gap_phase("f4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
